// File: rtl/seq_64_bit_adder_ctrl.sv
// Sequential 64-bit adder: a single SLICE_W-bit slice is reused LSB-first with a rippled carry register.
// Optional signed overflow flag is enabled by defining OVERFLOW_FLAG_EN.

module adder_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
endmodule

module seq_64_bit_adder_ctrl #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] input_a,
  input  logic [63:0] input_b,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] sum,
`ifdef OVERFLOW_FLAG_EN
  output logic        overflow,
`endif
  output logic        carry_out
);
  localparam int N_SLICES = 64 / SLICE_W;
  localparam int IDX_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               cy;
  logic [63:0]        op_a, op_b, acc, acc_nxt;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
  logic               sl_co, last;

  always_comb begin
    sl_a = op_a[idx*SLICE_W +: SLICE_W];
    sl_b = op_b[idx*SLICE_W +: SLICE_W];
    acc_nxt = acc;
    acc_nxt[idx*SLICE_W +: SLICE_W] = sl_s;
    last = (idx == IDX_W'(N_SLICES-1));
  end

  adder_slice #(.W(SLICE_W)) u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (cy),
    .s  (sl_s),
    .co (sl_co)
  );

`ifdef OVERFLOW_FLAG_EN
  // carry into the MSB recovered from the slice's own top bit
  logic sl_cmsb;
  assign sl_cmsb = sl_a[SLICE_W-1] ^ sl_b[SLICE_W-1] ^ sl_s[SLICE_W-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cy        <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          acc <= acc_nxt;
          cy  <= sl_co;
          if (last) begin
            sum       <= acc_nxt;
            carry_out <= sl_co;
`ifdef OVERFLOW_FLAG_EN
            overflow  <= sl_cmsb ^ sl_co;
`endif
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE share the accept path so back-to-back starts skip IDLE
          done <= 1'b0;
          if (start) begin
            op_a  <= input_a;
            op_b  <= input_b;
            cy    <= carry_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_64_bit_adder_ctrl.sv
// Bench for seq_64_bit_adder_ctrl: three slice widths (8/16/64) checked against a plain-arithmetic model.
module tb_seq_64_bit_adder_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [3];
  logic [63:0] a, b;
  logic        cin;
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [63:0] sum_v   [3];
  logic        co_v    [3];
  logic        ov_v    [3];
  int          nsl     [3];

  int n_vec = 0;
  int n_err = 0;

  seq_64_bit_adder_ctrl #(.SLICE_W(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .input_a(a), .input_b(b), .carry_in(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]),
`ifdef OVERFLOW_FLAG_EN
    .overflow(ov_v[0]),
`endif
    .carry_out(co_v[0]));

  seq_64_bit_adder_ctrl #(.SLICE_W(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .input_a(a), .input_b(b), .carry_in(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]),
`ifdef OVERFLOW_FLAG_EN
    .overflow(ov_v[1]),
`endif
    .carry_out(co_v[1]));

  seq_64_bit_adder_ctrl #(.SLICE_W(64)) u_d64 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .input_a(a), .input_b(b), .carry_in(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]),
`ifdef OVERFLOW_FLAG_EN
    .overflow(ov_v[2]),
`endif
    .carry_out(co_v[2]));

`ifndef OVERFLOW_FLAG_EN
  initial for (int i = 0; i < 3; i++) ov_v[i] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge; checks busy span, latency and single done.
  task automatic wait_done(input int d, input string tag);
    int cnt = 0;
    int bcnt = 0;
    bit seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy_v[d] && done_v[d]) chk({tag, "_busy_and_done"}, 1, 0);
      if (busy_v[d]) bcnt++;
      if (done_v[d]) begin seen = 1; break; end
      step();
      cnt++;
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_latency"}, 65'(cnt), 65'(nsl[d]));
    chk({tag, "_busy_cycles"}, 65'(bcnt), 65'(nsl[d]));
  endtask

  task automatic chk_result(input int d, input string tag,
                            input logic [63:0] ea, input logic [63:0] eb, input logic ec);
    logic [64:0] full;
    logic [63:0] s;
    full = {1'b0, ea} + {1'b0, eb} + 65'(ec);
    s = full[63:0];
    chk({tag, "_sum"}, 65'(sum_v[d]), 65'(s));
    chk({tag, "_cout"}, 65'(co_v[d]), 65'(full[64]));
`ifdef OVERFLOW_FLAG_EN
    chk({tag, "_ovf"}, 65'(ov_v[d]), 65'((ea[63] == eb[63]) && (s[63] != ea[63])));
`endif
  endtask

  task automatic do_op(input int d, input string tag,
                       input logic [63:0] xa, input logic [63:0] xb, input logic xc);
    a = xa; b = xb; cin = xc; start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom);   // operands free after acceptance
    wait_done(d, tag);
    chk_result(d, tag, xa, xb, xc);
    step();
    chk({tag, "_done_pulse"}, 65'(done_v[d]), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    int dn;
    logic [63:0] ra, rb;
    nsl[0] = 8; nsl[1] = 4; nsl[2] = 1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 65'(busy_v[i]), 0);
      chk("rst_done", 65'(done_v[i]), 0);
      chk("rst_sum",  65'(sum_v[i]), 0);
      chk("rst_cout", 65'(co_v[i]), 0);
      chk("rst_ovf",  65'(ov_v[i]), 0);
    end

    for (int i = 0; i < 3; i++) begin
      do_op(i, "basic", 64'd1245634, 64'd87903422, 1'b1);
      chk("basic_abs", 65'(sum_v[i]), 65'd89149057);
    end

    do_op(1, "xslice", 64'd90909, 64'd6452748058, 1'b0);
    chk("xslice_abs", 65'(sum_v[1]), 65'd6452838967);

    // back-to-back: start stays high into DONE
    a = 64'd90909; b = 64'd6452748058; cin = 1'b0; start_v[1] = 1'b1;
    step();
    a = 64'd9999; b = 64'd2222; cin = 1'b0;
    wait_done(1, "b2b_first");
    chk_result(1, "b2b_first", 64'd90909, 64'd6452748058, 1'b0);
    step();
    start_v[1] = 1'b0;
    chk("b2b_no_idle", 65'(busy_v[1]), 1);
    wait_done(1, "b2b_second");
    chk("b2b_second_sum", 65'(sum_v[1]), 65'd12221);
    step();

    for (int i = 0; i < 3; i++) begin
      do_op(i, "ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      do_op(i, "ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    end

    // start pulsed with other operands in RUN cycle 2 must be ignored
    a = 64'd8691649; b = 64'd2; cin = 1'b1; start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    step();
    a = 64'd12345; b = 64'd777; cin = 1'b0; start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    dn = 0;
    for (int i = 0; i < 15; i++) begin
      if (done_v[1]) begin
        dn++;
        chk("ignore_sum", 65'(sum_v[1]), 65'd8691652);
      end
      step();
    end
    chk("ignore_one_done", 65'(dn), 1);

    // reset during RUN cycle 3 aborts with no done
    a = 64'd5555; b = 64'd6666; cin = 1'b0; start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    step(); step();
    chk("midrst_busy_before", 65'(busy_v[1]), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_busy", 65'(busy_v[1]), 0);
    chk("midrst_done", 65'(done_v[1]), 0);
    chk("midrst_sum",  65'(sum_v[1]), 0);
    chk("midrst_cout", 65'(co_v[1]), 0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_v[1]) dn++;
      step();
    end
    chk("midrst_no_done", 65'(dn), 0);

    for (int k = 0; k < 24; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      do_op(k % 3, "rand", ra, rb, 1'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_64_bit_adder_ctrl.md
# seq_64_bit_adder_ctrl

Multi-cycle sequencer that performs a 64-bit add (a + b + carry_in) by driving a single SLICE_W-bit adder slice over successive clock cycles, rippling the carry through a register between slices. It sits alongside the combinational 64-bit adder as the area-reduced alternative: operands are latched on a start handshake, processed least-significant slice first, and the full result is presented with a one-cycle done pulse. It is the control and sequencing point for the shared narrow adder resource.

## Interface
- SLICE_W, 16, width of the internal adder slice; must divide 64 (legal: 8, 16, 32, 64)
- N_SLICES, 64/SLICE_W, derived localparam; number of RUN cycles
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  reset is synchronous and active-low
- start  input  1  request; sampled only in IDLE or DONE
- input_a  input  64  operand A, latched when start is accepted
- input_b  input  64  operand B, latched when start is accepted
- carry_in  input  1  carry into bit 0, latched when start is accepted
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  64  registered result; holds until the next completion
- carry_out  output  1  carry out of bit 63; registered with sum
- overflow  output  1  signed overflow; present only with OVERFLOW_FLAG_EN

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 -> latch input_a, input_b and carry_in into operand registers; clear slice index to 0; go to RUN.
  - start=0 -> stay in IDLE.
- RUN: each cycle, the slice adds operand slice [idx*SLICE_W +: SLICE_W] of A and B plus the carry register.
  - Write the slice sum into the matching slice of an internal accumulator.
  - Write the slice carry into the carry register.
  - idx increments by 1.
  - When idx = N_SLICES-1, the cycle completes the last slice and the state goes to DONE.
  - At that edge, load sum from the accumulator (last slice included) and load carry_out from the final slice carry.
- DONE: done=1 for exactly this cycle.
  - start=1 -> accept new operands (back-to-back) and go to RUN.
  - start=0 -> go to IDLE.
- start in RUN is ignored and not queued. Operand inputs may change freely after acceptance.
- sum and carry_out change only on the edge that enters DONE. They are stable in IDLE, RUN and DONE otherwise.
- Arithmetic is unsigned modulo 2^64. carry_out is bit 64 of a + b + carry_in.

## Timing
- Reset, when rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, sum=0, carry_out=0, overflow=0, idx=0, carry register=0, operand registers=0.
- Reset has priority over every other event, including reset during RUN: the operation is aborted and no done is issued.
- Latency: start accepted at edge k.
  - busy=1 for the cycles following edges k .. k+N_SLICES-1.
  - Result registered at edge k+N_SLICES; done=1 in the cycle that follows.
  - SLICE_W=16 gives 4 busy cycles; done appears 4 cycles after acceptance.
- Throughput: with start held high, one result every N_SLICES+1 cycles.
- busy and done are never high together.
- SLICE_W=64 degenerates to a single RUN cycle with identical handshake rules.

## Configuration
- OVERFLOW_FLAG_EN defined:
  - The overflow port exists.
  - It is computed as the carry into bit 63 XOR the carry out of bit 63, taken from the last slice.
  - It is registered with sum and reset to 0.
- OVERFLOW_FLAG_EN undefined: the overflow port and its logic are absent; all other behaviour is identical.

## Test plan
- Basic sum, SLICE_W=16:
  - Stimulus: reset; then a=1245634, b=87903422, carry_in=1, start pulse.
  - Required: busy high for 4 cycles, then done pulse; sum=89149057, carry_out=0.
- Cross-slice carry:
  - Stimulus: a=90909, b=6452748058, carry_in=0.
  - Required: sum=6452838967, carry_out=0.
  - Back-to-back, with start still high in DONE: a=9999, b=2222 is accepted with no IDLE cycle; sum=12221.
- Full ripple:
  - Stimulus: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, carry_in=1.
  - Required: sum=0, carry_out=1.
  - With OVERFLOW_FLAG_EN: a=64'h7FFF_FFFF_FFFF_FFFF, b=0, carry_in=1 gives overflow=1, carry_out=0.
- Start ignored while busy:
  - Stimulus: accept a=8691649, b=2, carry_in=1; pulse start with different operands in RUN cycle 2.
  - Required: sum=8691652 and exactly one done pulse.
- Reset mid-operation:
  - Stimulus: rst_n=0 during RUN cycle 3.
  - Required: the next cycle shows busy=0, done=0, sum=0, carry_out=0; no done follows until a new start.
- Parameter sweep:
  - Stimulus: repeat the first scenario with SLICE_W=8 and SLICE_W=64.
  - Required: done appears 8 and 1 cycles after acceptance respectively; results are identical.
